// File: rtl/data_mem_interface.sv
// Load/store unit between the core MEM stage and a word-wide req/ack data bus.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module data_mem_interface #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic              RAM_rw,
  input  logic [2:0]        RAM_DATA_control,
  input  logic [ADDR_W-1:0] RAM_Addr_o,
  input  logic [31:0]       RAM_DATA_o,
  output logic [31:0]       MEM_result_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  // Counter only needs to reach TIMEOUT_CYC-1: expiry is detected on the last waiting cycle.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic               we_reg;
  logic [2:0]         f3_reg;
  logic [31:0]        wdata_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_reg;
  logic [31:0]        result_reg;

  logic               misalign;
  logic               timeout_hit;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_val;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((RAM_DATA_control[1:0] == 2'b01) && RAM_Addr_o[0]) ||
                    (RAM_DATA_control[1] && (RAM_Addr_o[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST);

  // Lane steering; ignoring a[0] for halves and a[1:0] for words forces alignment.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_be[gi] = (f3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                           (f3_reg[1:0] == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) : 1'b1;
      assign lane_wdata[8*gi +: 8] = (f3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                     (f3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi % 2) +: 8] :
                                                              wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = mem_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
    half_sel = mem_rdata_i[{addr_reg[1], 4'b0000} +: 16];
    case (f3_reg)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid_i) state_next = misalign ? RESP : BUS;
      BUS:     if (mem_ack_i || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      f3_reg     <= 3'b000;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid_i) begin
          addr_reg  <= RAM_Addr_o;
          we_reg    <= RAM_rw;
          f3_reg    <= RAM_DATA_control;
          wdata_reg <= RAM_DATA_o;
          cnt_reg   <= '0;
          err_reg   <= misalign;
          if (misalign) result_reg <= '0;
        end
        BUS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack_i) begin
            result_reg <= load_val;
            err_reg    <= 1'b0;
          end else if (timeout_hit) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_reg)
      IDLE: stall_o = req_valid_i;
      BUS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_reg;
        mem_be_o    = lane_be;
        mem_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
        mem_wdata_o = lane_wdata;
        stall_o     = 1'b1;
      end
      RESP: begin
        done_o = 1'b1;
        err_o  = err_reg;
      end
      default: ;
    endcase
  end

  assign MEM_result_o = result_reg;

endmodule
